division_secuencial: RTL and testbench

Sequential restoring divider, the inverse of the combinational `multiplicacion` block: it takes an unsigned dividend and divisor and produces quotient and remainder, one quotient bit per clock. It sits beside the multiplier in the arithmetic unit. A start/done handshake lets a controller recover the operands of a product, for example 130 / 10 = 13. It is the first multi-cycle arithmetic block in the unit.

---
 rtl/division_pkg.sv | 19 +
 rtl/division_paso.sv | 30 +++
 rtl/division_secuencial.sv | 153 +++++++++++++++
 tb/tb_division_secuencial.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/division_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package division_pkg;

    // Controller states: waiting, one restoring step per cycle, result hand-off
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    // Step-counter width for a given operand width (at least one bit)
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/division_paso.sv
// One combinational restoring-division step: shift {rem, quo} left, try to
// subtract the divisor, keep the difference when it does not go negative.
module division_paso #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // The partial remainder stays below the divisor, so the shifted value fits
    // WIDTH+1 bits and the top bit of the difference acts as the borrow flag.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_sh[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/division_secuencial.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional build macro DIVISION_ZERO_DETECT_EN: a zero divisor skips the
// iteration and reports div_zero; without it the iteration runs normally and
// div_zero stays low. Both builds give q = all ones, r = a for b = 0.
module division_secuencial
    import division_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_BITS = cnt_width(WIDTH);

    state_t                state;
    logic [WIDTH-1:0]      rem_p0;
    logic [WIDTH-1:0]      quo_p0;
    logic [WIDTH-1:0]      div_p0;
    logic [CNT_BITS-1:0]   cnt;
    logic [WIDTH-1:0]      rem_nx;
    logic [WIDTH-1:0]      quo_nx;
    logic                  accept;

    division_paso #(.WIDTH(WIDTH)) u_paso (
        .rem      (rem_p0),
        .quo      (quo_p0),
        .divisor  (div_p0),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    // A new request is taken whenever no division is iterating
    assign accept = start && (state != RUN);

`ifdef DIVISION_ZERO_DETECT_EN
    logic zero_p0;

    // Controller, working registers and registered outputs (zero-detect build)
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rem_p0   <= '0;
            quo_p0   <= '0;
            div_p0   <= '0;
            cnt      <= '0;
            zero_p0  <= 1'b0;
            q        <= '0;
            r        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FIN) begin
                q        <= quo_p0;
                r        <= rem_p0;
                div_zero <= zero_p0;
                done     <= 1'b1;
            end
            if (accept) begin
                div_p0 <= b;
                cnt    <= CNT_BITS'(WIDTH - 1);
                if (b == '0) begin
                    // Result is known immediately: all-ones quotient, remainder a
                    state   <= FIN;
                    quo_p0  <= '1;
                    rem_p0  <= a;
                    zero_p0 <= 1'b1;
                    busy    <= 1'b0;
                end else begin
                    state   <= RUN;
                    quo_p0  <= a;
                    rem_p0  <= '0;
                    zero_p0 <= 1'b0;
                    busy    <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        rem_p0 <= rem_nx;
                        quo_p0 <= quo_nx;
                        if (cnt == '0) begin
                            state <= FIN;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
`else
    assign div_zero = 1'b0;

    // Controller, working registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rem_p0 <= '0;
            quo_p0 <= '0;
            div_p0 <= '0;
            cnt    <= '0;
            q      <= '0;
            r      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FIN) begin
                q    <= quo_p0;
                r    <= rem_p0;
                done <= 1'b1;
            end
            if (accept) begin
                state  <= RUN;
                quo_p0 <= a;
                rem_p0 <= '0;
                div_p0 <= b;
                cnt    <= CNT_BITS'(WIDTH - 1);
                busy   <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        rem_p0 <= rem_nx;
                        quo_p0 <= quo_nx;
                        if (cnt == '0) begin
                            state <= FIN;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_division_secuencial.sv
// Directed bench for division_secuencial at WIDTH = 8.
module tb_division_secuencial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [7:0] q;
    logic [7:0] r;
    logic       busy;
    logic       done;
    logic       div_zero;

    int errors = 0;
    int checks = 0;

    division_secuencial #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present operands with start for exactly one rising edge (edge E0)
    task automatic issue(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen high, bounded
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < 40);
    endtask

    task automatic divide(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input int lat, input logic [7:0] eq, input logic [7:0] er,
                          input logic edz);
        int n;
        issue(av, bv);
        wait_done(n);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_r"}, r, er);
        chk({tag, "_dz"}, div_zero, edz);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        int n;
        int stray;
        int zlat;
        logic zdz;

`ifdef DIVISION_ZERO_DETECT_EN
        zlat = 1;
        zdz  = 1'b1;
`else
        zlat = 9;
        zdz  = 1'b0;
`endif

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);

        divide("d130_10", 8'd130, 8'd10, 9, 8'd13, 8'd0, 1'b0);

        // 200/7, then 16/2 requested while the first result is being handed off
        issue(8'd200, 8'd7);
        chk("b2b_busy", busy, 1);
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_fin_busy", busy, 0);
        a     = 8'd16;
        b     = 8'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_done1", done, 1);
        chk("b2b_q1", q, 28);
        chk("b2b_r1", r, 4);
        chk("b2b_busy2", busy, 1);
        wait_done(n);
        chk("b2b_lat2", n, 9);
        chk("b2b_q2", q, 8);
        chk("b2b_r2", r, 0);

        // A start during RUN must not disturb the division in flight
        @(posedge clk);
        issue(8'd45, 8'd3);
        repeat (3) @(posedge clk);
        #1;
        a     = 8'd27;
        b     = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("ign_lat", n, 5);
        chk("ign_q", q, 15);
        chk("ign_r", r, 0);
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        chk("ign_no_second", stray, 0);

        divide("d255_1", 8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
        divide("d5_9", 8'd5, 8'd9, 9, 8'd0, 8'd5, 1'b0);
        divide("d99_0", 8'd99, 8'd0, zlat, 8'd255, 8'd99, zdz);

        // Reset in the middle of a division: outputs cleared, no done appears
        issue(8'd130, 8'd10);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dz", div_zero, 0);
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) stray++;
        end
        chk("abort_no_done", stray, 0);

        divide("d27_3", 8'd27, 8'd3, 9, 8'd9, 8'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
